// File: rtl/mpu_pkg.sv
// Shared widths, FSM encoding and element helpers for the MPU integer divider.
package mpu_pkg;
  localparam int ELEM_W      = 8;
  localparam int N_ELEMS     = 25;
  localparam int MATRIX_W    = 200;
  localparam int DIV_STEPS   = 8;
  localparam int ELEM_CYCLES = 10;

  localparam logic [4:0] LAST_IDX = 5'(N_ELEMS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ITER  = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int unsigned elem_off(input int unsigned row, input int unsigned col);
    return ELEM_W * (row + 5 * col);
  endfunction

  // Magnitude as unsigned 8-bit; -128 maps to 128 rather than wrapping.
  function automatic logic [7:0] abs8(input logic [7:0] v);
    logic [7:0] m;
    if (v[7]) m = ~v + 8'd1;
    else      m = v;
    return m;
  endfunction
endpackage

// File: rtl/mpu_div8_core.sv
// Unsigned 8-bit restoring divider datapath: one quotient bit per step, MSB first.
module mpu_div8_core
  import mpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ELEM_W-1:0] i_dividend,
  input  logic [ELEM_W-1:0] i_divisor,
  output logic [ELEM_W-1:0] o_quotient,
  output logic              o_last_step
);
  logic [7:0] r_rem;
  logic [7:0] r_quo;
  logic [7:0] r_dvs;
  logic [3:0] r_cnt;
  logic [8:0] w_shift;
  logic [7:0] w_diff;
  logic       w_fits;

  // Trial subtraction; the partial remainder stays below the divisor, so 8 bits hold it.
  always_comb begin
    w_shift = {r_rem, r_quo[7]};
    w_fits  = (w_shift >= {1'b0, r_dvs});
    w_diff  = w_shift[7:0] - r_dvs;
  end

  // Remainder/quotient shift register and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= 8'd0;
      r_quo <= 8'd0;
      r_dvs <= 8'd0;
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_rem <= 8'd0;
      r_quo <= i_dividend;
      r_dvs <= i_divisor;
      r_cnt <= 4'd0;
    end else if (i_step) begin
      r_rem <= w_fits ? w_diff : w_shift[7:0];
      r_quo <= {r_quo[6:0], w_fits};
      r_cnt <= r_cnt + 4'd1;
    end else begin
      r_rem <= r_rem;
      r_quo <= r_quo;
      r_dvs <= r_dvs;
      r_cnt <= r_cnt;
    end
  end

  assign o_quotient  = r_quo;
  assign o_last_step = (r_cnt == 4'(DIV_STEPS - 1));
endmodule

// File: rtl/mpu_int_div.sv
// Element-wise signed division of a 5x5 int8 matrix by one int8 divisor, one element at a time.
module mpu_int_div
  import mpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [MATRIX_W-1:0] matrix_a,
  input  logic [ELEM_W-1:0]   divisor,
  output logic [MATRIX_W-1:0] result,
  output logic                busy,
  output logic                done,
  output logic                div_by_zero,
  output logic                overflow
);
  state_e              r_state;
  logic [MATRIX_W-1:0] r_a;
  logic [ELEM_W-1:0]   r_d;
  logic [4:0]          r_idx;
  logic                r_neg;
  logic [MATRIX_W-1:0] r_result;
  logic                r_busy;
  logic                r_done;
  logic                r_dbz;
  logic                r_ovf;

  logic [7:0]          w_off;
  logic [ELEM_W-1:0]   w_a_elem;
  logic [ELEM_W-1:0]   w_quo;
  logic                w_last_step;
  logic                w_sat;
  logic [ELEM_W-1:0]   w_elem;

  // Current element select and signed/saturated quotient for the STORE cycle.
  always_comb begin
    w_off    = {r_idx, 3'b000};
    w_a_elem = r_a[w_off +: ELEM_W];
    w_sat    = !r_neg && (w_quo == 8'h80);
    if (w_sat)      w_elem = 8'h7F;
    else if (r_neg) w_elem = 8'd0 - w_quo;
    else            w_elem = w_quo;
  end

  mpu_div8_core u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (r_state == ST_LOAD),
    .i_step      (r_state == ST_ITER),
    .i_dividend  (abs8(w_a_elem)),
    .i_divisor   (abs8(r_d)),
    .o_quotient  (w_quo),
    .o_last_step (w_last_step)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_d      <= 8'd0;
      r_idx    <= 5'd0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a      <= matrix_a;
            r_d      <= divisor;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_idx    <= 5'd0;
            r_busy   <= 1'b1;
            if (divisor == 8'd0) begin
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_dbz   <= 1'b0;
              r_state <= ST_LOAD;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          r_neg   <= w_a_elem[7] ^ r_d[7];
          r_state <= ST_ITER;
        end
        ST_ITER: begin
          if (w_last_step) r_state <= ST_STORE;
          else             r_state <= ST_ITER;
        end
        ST_STORE: begin
          r_result[w_off +: ELEM_W] <= w_elem;
          if (w_sat) r_ovf <= 1'b1;
          else       r_ovf <= r_ovf;
          if (r_idx == LAST_IDX) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx   <= r_idx + 5'd1;
            r_state <= ST_LOAD;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign result      = r_result;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;
endmodule

// File: tb/tb_mpu_int_div.sv
// Scoreboard bench for mpu_int_div: randomized and directed operations against an arithmetic model.
module tb_mpu_int_div;
  import mpu_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [MATRIX_W-1:0] matrix_a;
  logic [ELEM_W-1:0]   divisor;
  logic [MATRIX_W-1:0] result;
  logic                busy;
  logic                done;
  logic                div_by_zero;
  logic                overflow;

  typedef struct {
    logic [MATRIX_W-1:0] res;
    logic                dbz;
    logic                ovf;
    int                  done_edge;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   edge_cnt = 0;
  bit   chk_busy_low = 0;

  mpu_int_div dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .matrix_a    (matrix_a),
    .divisor     (divisor),
    .result      (result),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  task automatic chk(input string nm, input logic [MATRIX_W-1:0] act, input logic [MATRIX_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain signed integer division, truncating toward zero, saturating +128.
  function automatic exp_t model(input logic [MATRIX_W-1:0] m, input logic [7:0] d);
    exp_t e;
    int a, dv, q;
    e.res = '0; e.dbz = 1'b0; e.ovf = 1'b0; e.done_edge = 0;
    dv = int'($signed(d));
    if (dv == 0) begin
      e.dbz = 1'b1;
      return e;
    end
    for (int k = 0; k < N_ELEMS; k++) begin
      a = int'($signed(m[8*k +: 8]));
      q = a / dv;
      if (q > 127) begin
        q = 127;
        e.ovf = 1'b1;
      end
      e.res[8*k +: 8] = q[7:0];
    end
    return e;
  endfunction

  function automatic logic [MATRIX_W-1:0] fill(input logic [7:0] v);
    logic [MATRIX_W-1:0] m;
    for (int k = 0; k < N_ELEMS; k++) m[elem_off(k % 5, k / 5) +: 8] = v;
    return m;
  endfunction

  function automatic logic [MATRIX_W-1:0] rand_mat();
    logic [MATRIX_W-1:0] m;
    for (int k = 0; k < N_ELEMS; k++) m[8*k +: 8] = 8'($urandom);
    return m;
  endfunction

  // Drives one accepted start; done is due in cycle 251 (or cycle 1 on a zero divisor).
  task automatic issue(input logic [MATRIX_W-1:0] m, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    matrix_a = m; divisor = d; start = 1'b1;
    e = model(m, d);
    e.done_edge = edge_cnt + 1 + ((d == 8'd0) ? 0 : 250);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int extra);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: got no done, expected %0d pending", sb.size());
      sb.delete();
    end
    repeat (extra) @(negedge clk);
  endtask

  // Monitor: pops the oldest expectation whenever done is presented.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (chk_busy_low) begin
        chk("busy_after_done", {199'd0, busy}, '0);
        chk_busy_low = 0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done: got done=1 expected 0 at edge %0d", edge_cnt);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("div_by_zero", {199'd0, div_by_zero}, {199'd0, e.dbz});
          chk("overflow", {199'd0, overflow}, {199'd0, e.ovf});
          chk("busy_at_done", {199'd0, busy}, {199'd0, 1'b1});
          chk("done_edge", MATRIX_W'(edge_cnt), MATRIX_W'(e.done_edge));
          chk_busy_low = 1;
        end
      end
    end
  end

  task automatic chk_outputs_zero();
    chk("rst_result", result, '0);
    chk("rst_busy", {199'd0, busy}, '0);
    chk("rst_done", {199'd0, done}, '0);
    chk("rst_dbz", {199'd0, div_by_zero}, '0);
    chk("rst_ovf", {199'd0, overflow}, '0);
  endtask

  initial begin
    logic [MATRIX_W-1:0] m;
    logic [7:0] d;
    start = 1'b0; matrix_a = '0; divisor = 8'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero();
    rst_n = 1'b1;

    // Uniform 100 / 7.
    issue(fill(8'd100), 8'd7);
    wait_drain(3);

    // Sign and overflow mix.
    m = fill(8'd1);
    m[0 +: 8] = 8'hF9; m[8 +: 8] = 8'd7; m[16 +: 8] = 8'h80;
    m[24 +: 8] = 8'h80; m[32 +: 8] = 8'd0; m[40 +: 8] = 8'd127;
    issue(m, 8'd2);
    wait_drain(2);
    issue(m, 8'hFF);
    wait_drain(2);

    // Divide by zero.
    issue(rand_mat(), 8'd0);
    wait_drain(2);

    // Input isolation: extra start and new operands in cycle 50.
    issue(rand_mat(), 8'hFD);
    repeat (49) @(negedge clk);
    start = 1'b1; matrix_a = rand_mat(); divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wait_drain(260);

    // Reset in cycle 100, then a fresh 64 / 8.
    issue(rand_mat(), 8'd3);
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk_busy_low = 0;
    chk_outputs_zero();
    @(negedge clk);
    rst_n = 1'b1;
    issue(fill(8'd64), 8'd8);
    wait_drain(2);

    // Divisor -128.
    m = rand_mat();
    m[0 +: 8] = 8'd127; m[8 +: 8] = 8'h80; m[16 +: 8] = 8'hFF;
    issue(m, 8'h80);
    wait_drain(2);

    // Randomized operations with edge-heavy divisors.
    for (int t = 0; t < 6; t++) begin
      case ($urandom_range(0, 5))
        0: d = 8'd0;
        1: d = 8'd1;
        2: d = 8'hFF;
        3: d = 8'h80;
        default: d = 8'($urandom);
      endcase
      issue(rand_mat(), d);
      wait_drain(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mpu_int_div.md
# mpu_int_div

Sequential element-wise signed division of a 5x5 matrix of 8-bit integers by one 8-bit signed divisor. This is the inverse companion of the MPU's combinational scalar-multiply unit, used to normalise Laplace/Sobel kernel outputs. It uses one shared restoring divider that processes the 25 elements one after another. A start/done handshake connects it to the MPU controller.

## Interface
- No parameters; all widths are fixed constants in `mpu_pkg`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `matrix_a`  in  200  signed 5x5 matrix, flattened; element (col,row) at bit offset 8*(row+5*col).
- `divisor`  in  8  signed divisor.
- `result`  out  200  quotient matrix, same layout; reset value 0.
- `busy`  out  1  high from the cycle after an accepted start through the done cycle; reset 0.
- `done`  out  1  one-cycle completion pulse; reset 0.
- `div_by_zero`  out  1  sticky per operation; reset 0.
- `overflow`  out  1  sticky per operation; reset 0.

## Operation
- States: IDLE, LOAD, ITER, STORE, DONE.
- **IDLE**
  - `start`=1 latches `matrix_a` and `divisor`, clears `result`, `div_by_zero` and `overflow`, and sets element index 0.
  - Divisor nonzero: go to LOAD. Divisor zero: set `div_by_zero`, leave `result` at 0, go straight to DONE.
- **LOAD**: load |a[idx]| and |divisor| as 8-bit unsigned values (|-128| = 128) and record quotient sign = sign(a) XOR sign(d). Go to ITER.
- **ITER**: 8 cycles of restoring division, one quotient bit per cycle, MSB first. Go to STORE.
- **STORE**
  - Apply the quotient sign. Truncate toward zero; the remainder is discarded.
  - Positive magnitude 128 (only -128 / -1) saturates to +127 and sets `overflow`.
  - Write the element into `result` at offset 8*idx.
  - idx < 24: increment idx and go to LOAD. idx = 24: go to DONE.
- **DONE**: `done`=1 for exactly one cycle, then IDLE.
- `start` is ignored whenever the state is not IDLE.
- Changes to `matrix_a` or `divisor` after acceptance have no effect on the operation.
- `result` and both flags hold their values until the next accepted start.
- Zero dividend gives quotient 0 with no special path.

## Timing
- Start accepted at edge of cycle 0.
- Element k occupies cycles 1+10k (LOAD) .. 10+10k (STORE).
- DONE at cycle 251; `result` is valid from cycle 251. IDLE at cycle 252, where a new start may be accepted.
- Divide-by-zero path: DONE at cycle 1, IDLE at cycle 2.
- `busy` is high in LOAD, ITER, STORE and DONE.
- An element's `result` bits update at the end of its STORE cycle. Partial results are visible while busy but are not guaranteed meaningful.
- Reset asserted at any time returns the block to IDLE immediately: all outputs 0, internal registers cleared, any operation in progress is abandoned. The first start after reset behaves normally.

## Structure
- **`mpu_pkg`** holds:
  - constants ELEM_W=8, N_ELEMS=25, MATRIX_W=200, DIV_STEPS=8, ELEM_CYCLES=10;
  - the state enum;
  - the element-offset function 8*(row+5*col).
- **`mpu_div8_core`** is the one natural sub-module: an unsigned 8-bit restoring divider step datapath.
  - It holds the remainder/quotient registers and a step counter.
  - Its controls are load and step; it outputs the quotient.
  - The top level owns the FSM, sign handling, saturation and result packing.

## Test plan
- **Uniform values:** all elements 100, divisor 7, start at cycle 0.
  - Every element 14, `done` only at cycle 251, `busy` low at 252, both flags 0.
- **Sign and overflow mix:** elements {-7, 7, -128, -128, 0, 127}, rest 1.
  - Divisor 2 -> {-3, 3, -64, -64, 0, 63}.
  - Divisor -1 -> {7, -7, 127, 127, 0, -127}, with `overflow`=1.
- **Divide by zero:** divisor 0, any matrix.
  - `done` at cycle 1, `result`=0, `div_by_zero`=1, `busy` high only in cycle 1.
- **Input isolation:** pulse `start` and change `matrix_a`/`divisor` at cycle 50 during an operation.
  - Result matches the originally latched operands, and exactly one `done` pulse occurs.
- **Reset mid-operation:** assert `rst_n`=0 at cycle 100.
  - All outputs 0 immediately; a fresh start (all 64 / 8) yields all 8 at cycle 251 after that start.
- **Divisor -128:** elements {127, -128, -1}.
  - Quotients {0, 1, 0}, `overflow`=0.
